note_sequencer: RTL and testbench
=================================

# note_sequencer

Controller that steps the music player through a song stored in note ROM, sequencing the `time_advancer` one note at a time. It fetches each note/duration word, pulses `load_duration` to start the advancer, and gates `beat` while playing. It waits for `advance_done`, then moves to the next note until an end marker or the last ROM slot. It sits between the song ROM, the time advancer and the note player.

## Interface
Parameters:
- `SONG_W`, 2: song-select width; ROM holds 2^SONG_W songs.
- `NOTE_W`, 5: note-index width; 2^NOTE_W slots per song.

Ports:
- `clk`, in, 1: single clock; all state changes on rising edge.
- `reset`, in, 1: asynchronous, active-low reset; 0 clears all state immediately.
- `play`, in, 1: play/pause level.
- `song`, in, SONG_W: song select, sampled only on start.
- `rom_addr`, out, SONG_W+NOTE_W: registered ROM address `{song_q, index}`.
- `rom_data`, in, 12: `{note[11:6], duration[5:0]}`; valid one cycle after `rom_addr` changes.
- `beat`, in, 1: one-cycle beat pulse from the beat generator.
- `advance_done`, in, 1: time advancer finished current duration.
- `beat_out`, out, 1: `beat & play` while in WAIT, else 0; feeds the advancer.
- `load_duration`, out, 1: one-cycle pulse, advancer loads `duration`.
- `note`, out, 6: current note, held until next LOAD.
- `duration`, out, 6: current duration, held until next LOAD.
- `new_note`, out, 1: one-cycle pulse coincident with `load_duration`.
- `song_done`, out, 1: one-cycle pulse at end of song.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Reset values: state IDLE, index 0, song_q 0, play_q 0, all outputs 0.
- `play_q` is a registered copy of `play`; start event = `play & ~play_q`.
- States:
  - IDLE: on start event, song_q <= `song`, index <= 0, go FETCH. Otherwise stay.
  - FETCH: `rom_addr` = `{song_q, index}` is registered; go LATCH.
  - LATCH: rom_data valid. If `rom_data[5:0] == 0` (end marker), go DONE. Otherwise capture note/duration into internal regs and go LOAD.
  - LOAD: drive `note`/`duration` with the captured values, assert `load_duration` = `new_note` = 1, then go WAIT.
  - WAIT: `beat_out` = `beat & play`. On `advance_done`: if index == 2^NOTE_W−1, go DONE; else index <= index+1 and go FETCH.
  - DONE: `song_done` = 1 for one cycle, go IDLE.
- Pause: `play`=0 affects only `beat_out` in WAIT; the duration is frozen. FETCH/LATCH/LOAD complete regardless of `play`.
- `song` changes outside IDLE are ignored until the next start.
- Index arithmetic is unsigned NOTE_W-bit. The increment never wraps because of the last-slot check.
- `advance_done` outside WAIT is ignored.
- Reset asserted mid-song: immediate return to IDLE with all outputs 0. A restart requires a new `play` rising edge after reset release.

## Timing
- Start edge sampled at cycle t: FETCH at t+1, LATCH at t+2, `load_duration` at t+3, WAIT from t+4.
- `advance_done` at cycle w (in WAIT): FETCH at w+1, next `load_duration` at w+3. The inter-note gap is 3 cycles with no `beat_out`.
- End marker in LATCH at cycle l: DONE at l+1 (`song_done` high), IDLE at l+2. No `load_duration` is issued for the marker.
- Last slot: `advance_done` at w, then `song_done` at w+1.
- `load_duration`, `new_note` and `song_done` are never high for two consecutive cycles. `load_duration` and `song_done` are never high together.

## Configuration
- `SEQ_LOOP_EN`:
  - Defined: an end marker or last slot goes to FETCH with index <= 0 (same song_q) instead of DONE. `song_done` still pulses for one cycle, alongside the FETCH entry. `busy` stays 1. A song whose slot 0 is an end marker goes to IDLE with `song_done`, to avoid a livelock.
  - Undefined: behaviour as in Operation; playback stops in IDLE.

## Test plan
- Basic sequence: song 1 = {(note 10, dur 2), (note 20, dur 1), marker}; pulse `play` → `load_duration` with note 10/dur 2 at t+3; after `advance_done`, note 20/dur 1 three cycles later; `song_done` one cycle after the marker is latched; no third load.
- Pause: hold `play`=0 for 20 cycles in WAIT with `beat` toggling → `beat_out` stays 0, state WAIT, no load. Re-raise `play` → `beat_out` follows `beat` and no new start occurs.
- Full song: song 0 with all 32 slots nonzero → exactly 32 `load_duration` pulses. `rom_addr` reaches 0x1F, and `song_done` fires 1 cycle after the 32nd `advance_done`.
- Empty song: slot 0 = marker → no `load_duration`; `song_done` at t+3; `busy` low at t+4.
- Async reset mid-WAIT: drive `reset`=0 between clock edges → outputs 0 and `busy` 0 before the next edge. After release with `play` held 1, no restart occurs until `play` falls and rises again.
- `SEQ_LOOP_EN` defined: 2-note song → after the marker, `rom_addr` returns to `{song,0}` and `song_done` pulses once per loop. Three loops produce 6 loads.

Source files
------------

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Steps the music player through one song held in the note ROM. For every
// slot it fetches the {note, duration} word, pulses load_duration so the time
// advancer picks up the duration, then gates beat through to the advancer
// until advance_done comes back. Playback ends on an end marker (duration 0)
// or after the last slot of the song.
//
// Optional feature macro: SEQ_LOOP_EN
//   defined   - the song repeats from slot 0 instead of stopping. song_done
//               still pulses once per pass. A song whose slot 0 is a marker
//               stops in IDLE so the sequencer cannot spin forever.
//   undefined - playback stops in IDLE after the song.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   reset         in   asynchronous active-low reset
//   play          in   play/pause level; a rising edge starts a song
//   song          in   song select, sampled only when a song starts
//   rom_addr      out  registered ROM address {song_q, index}
//   rom_data      in   {note[11:6], duration[5:0]}, valid one cycle after
//                      rom_addr changes (synchronous ROM)
//   beat          in   one-cycle beat pulse
//   advance_done  in   time advancer finished the current duration
//   beat_out      out  beat & play while waiting on a note, else 0
//   load_duration out  one-cycle pulse: advancer loads duration
//   note          out  current note, held until the next load
//   duration      out  current duration, held until the next load
//   new_note      out  one-cycle pulse coincident with load_duration
//   song_done     out  one-cycle pulse at the end of a song (or pass)
//   busy          out  high in every state except IDLE
//   dbg_state     out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module note_sequencer #(
  parameter int SONG_W = 2,
  parameter int NOTE_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [SONG_W-1:0]        song,
  output logic [SONG_W+NOTE_W-1:0] rom_addr,
  input  logic [11:0]              rom_data,
  input  logic                     beat,
  input  logic                     advance_done,
  output logic                     beat_out,
  output logic                     load_duration,
  output logic [5:0]               note,
  output logic [5:0]               duration,
  output logic                     new_note,
  output logic                     song_done,
  output logic                     busy,
  output logic [2:0]               dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [NOTE_W-1:0] LAST_IDX = '1;

  logic [2:0]               r_state;
  logic [NOTE_W-1:0]        r_index;
  logic [SONG_W-1:0]        r_song_q;
  logic                     r_play_q;
  logic                     r_arm;
  logic [SONG_W+NOTE_W-1:0] r_rom_addr;
  logic [5:0]               r_note;
  logic [5:0]               r_duration;
  logic                     r_song_done;

  logic                     w_start;
  logic                     w_marker;
  logic                     w_last;
  logic [NOTE_W-1:0]        w_index_nx;

  // A start needs play to have been seen low since reset. play_q clears to 0
  // on reset, so without r_arm a play level held through reset would look
  // like a fresh rising edge on the first cycle after release.
  assign w_start    = play & ~r_play_q & r_arm;
  assign w_marker   = (rom_data[5:0] == 6'd0);
  assign w_last     = (r_index == LAST_IDX);
  // Never wraps: the last slot leaves WAIT without incrementing.
  assign w_index_nx = r_index + {{(NOTE_W-1){1'b0}}, 1'b1};

  // Advancer protocol: load_duration is a single-cycle strobe with note and
  // duration already stable on the same cycle; the advancer answers with a
  // single-cycle advance_done, which is only honoured in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_song_q    <= '0;
      r_play_q    <= 1'b0;
      r_arm       <= 1'b0;
      r_rom_addr  <= '0;
      r_note      <= 6'd0;
      r_duration  <= 6'd0;
      r_song_done <= 1'b0;
    end else begin
      r_play_q    <= play;
      r_song_done <= 1'b0;
      if (!play) begin
        r_arm <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_song_q   <= song;
            r_index    <= '0;
            // Address is presented during FETCH so the synchronous ROM
            // returns the word in LATCH.
            r_rom_addr <= {song, {NOTE_W{1'b0}}};
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          if (w_marker) begin
            r_song_done <= 1'b1;
`ifdef SEQ_LOOP_EN
            if (r_index == '0) begin
              r_state <= S_DONE;
            end else begin
              r_index    <= '0;
              r_rom_addr <= {r_song_q, {NOTE_W{1'b0}}};
              r_state    <= S_FETCH;
            end
`else
            r_state <= S_DONE;
`endif
          end else begin
            r_note     <= rom_data[11:6];
            r_duration <= rom_data[5:0];
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (advance_done) begin
            if (w_last) begin
              r_song_done <= 1'b1;
`ifdef SEQ_LOOP_EN
              r_index    <= '0;
              r_rom_addr <= {r_song_q, {NOTE_W{1'b0}}};
              r_state    <= S_FETCH;
`else
              r_state <= S_DONE;
`endif
            end else begin
              r_index    <= w_index_nx;
              r_rom_addr <= {r_song_q, w_index_nx};
              r_state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr      = r_rom_addr;
  assign note          = r_note;
  assign duration      = r_duration;
  assign load_duration = (r_state == S_LOAD);
  assign new_note      = (r_state == S_LOAD);
  assign song_done     = r_song_done;
  assign busy          = (r_state != S_IDLE);
  // Pausing only freezes the advancer; the sequencer itself keeps its state.
  assign beat_out      = (r_state == S_WAIT) & beat & play;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Bench for note_sequencer. A synchronous ROM model holds four songs; the
// expected {note, duration} words are queued when a song is started and
// popped as each load_duration appears. Inputs are driven and outputs sampled
// on the falling clock edge. Build with SEQ_LOOP_EN defined to exercise the
// looping variant.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int SONG_W = 2;
  localparam int NOTE_W = 5;
  localparam int AW     = SONG_W + NOTE_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic          clk;
  logic          reset;
  logic          play;
  logic [1:0]    song;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic          beat;
  logic          advance_done;
  logic          beat_out;
  logic          load_duration;
  logic [5:0]    note;
  logic [5:0]    duration;
  logic          new_note;
  logic          song_done;
  logic          busy;
  logic [2:0]    dbg_state;

  note_sequencer #(.SONG_W(SONG_W), .NOTE_W(NOTE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .song          (song),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .beat          (beat),
    .advance_done  (advance_done),
    .beat_out      (beat_out),
    .load_duration (load_duration),
    .note          (note),
    .duration      (duration),
    .new_note      (new_note),
    .song_done     (song_done),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / ROM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 12'h000;
    // song 0: all 32 slots playable
    for (int i = 0; i < 32; i++) rom_mem[i] = {6'(i + 1), 6'((i % 3) + 1)};
    // song 1: two notes then marker
    rom_mem[7'h20] = {6'd10, 6'd2};
    rom_mem[7'h21] = {6'd20, 6'd1};
    rom_mem[7'h22] = 12'h000;
    // song 2: one note then marker
    rom_mem[7'h40] = {6'd5, 6'd3};
    rom_mem[7'h41] = 12'h000;
    // song 3: empty (slot 0 is a marker)
  end

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];
  int n_tests;
  int n_fail;
  int n_loads;
  int n_dones;

  always @(negedge clk) begin
    if (load_duration === 1'b1) n_loads++;
    if (song_done === 1'b1) n_dones++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_song(input logic [1:0] s);
    play = 1'b0;
    song = s;
    @(negedge clk);
    @(negedge clk);
    play = 1'b1;
  endtask

  // Counts falling edges until load_duration (want_done=0) or song_done
  // (want_done=1) is seen; cycles = -1 if the bound expires. Any pending
  // advance_done pulse is dropped after one clock.
  task automatic wait_for(input bit want_done, input int limit, output int cycles);
    cycles = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      advance_done = 1'b0;
      if (want_done ? (song_done === 1'b1) : (load_duration === 1'b1)) begin
        cycles = c;
        break;
      end
    end
    advance_done = 1'b0;
  endtask

  function automatic logic [11:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 12'hFFF;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    beat  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, load_duration, new_note, song_done, beat_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {busy, load_duration, new_note, song_done, beat_out});
    end
    n_tests++;
    if ({rom_addr, note, duration} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%0h note=%0d dur=%0d want 0/0/0", rom_addr, note, duration);
    end
    n_tests++;
    if (dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
    end
    beat  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    int c;
    int loads0;
    int dones0;
    logic [11:0] e;
    loads0 = n_loads;
    dones0 = n_dones;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back({6'd10, 6'd2});
      exp_q.push_back({6'd20, 6'd1});
    end
    start_song(2'd1);
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 2; n++) begin
        wait_for(1'b0, 10, c);
        n_tests++;
        if (c !== ((n == 0) ? ((p == 0) ? 3 : 2) : 3)) begin
          n_fail++;
          $display("FAIL loop_load_latency p%0d n%0d: got %0d cycles", p, n, c);
        end
        e = pop_exp();
        n_tests++;
        if ({note, duration} !== e) begin
          n_fail++;
          $display("FAIL loop_word p%0d n%0d: got %0h want %0h", p, n, {note, duration}, e);
        end
        @(negedge clk);
        advance_done = 1'b1;
      end
      wait_for(1'b1, 10, c);
      n_tests++;
      if (c !== 3) begin
        n_fail++;
        $display("FAIL loop_done_latency p%0d: got %0d want 3", p, c);
      end
      n_tests++;
      if ({busy, rom_addr} !== {1'b1, 7'h20}) begin
        n_fail++;
        $display("FAIL loop_restart p%0d: got busy=%b addr=%0h want 1/20", p, busy, rom_addr);
      end
    end
    reset = 1'b0;
    play  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (n_loads - loads0 !== 6) begin
      n_fail++;
      $display("FAIL loop_load_count: got %0d want 6", n_loads - loads0);
    end
    n_tests++;
    if (n_dones - dones0 !== 3) begin
      n_fail++;
      $display("FAIL loop_done_count: got %0d want 3", n_dones - dones0);
    end
  endtask
`else
  task automatic test_basic();
    int c;
    int loads0;
    logic [11:0] e;
    loads0 = n_loads;
    exp_q.push_back({6'd10, 6'd2});
    exp_q.push_back({6'd20, 6'd1});
    start_song(2'd1);
    wait_for(1'b0, 10, c);
    n_tests++;
    if (c !== 3) begin n_fail++; $display("FAIL basic_first_latency: got %0d want 3", c); end
    e = pop_exp();
    n_tests++;
    if ({note, duration, new_note, rom_addr} !== {e, 1'b1, 7'h20}) begin
      n_fail++;
      $display("FAIL basic_first_load: got %0h nn=%b addr=%0h want %0h/1/20", {note, duration}, new_note, rom_addr, e);
    end
    @(negedge clk);
    n_tests++;
    if (dbg_state !== S_WAIT) begin n_fail++; $display("FAIL basic_wait_state: got %0d want %0d", dbg_state, S_WAIT); end
    advance_done = 1'b1;
    wait_for(1'b0, 10, c);
    n_tests++;
    if (c !== 3) begin n_fail++; $display("FAIL basic_gap: got %0d want 3", c); end
    e = pop_exp();
    n_tests++;
    if ({note, duration, rom_addr} !== {e, 7'h21}) begin
      n_fail++;
      $display("FAIL basic_second_load: got %0h addr=%0h want %0h/21", {note, duration}, rom_addr, e);
    end
    @(negedge clk);
    advance_done = 1'b1;
    wait_for(1'b1, 10, c);
    n_tests++;
    if (c !== 3) begin n_fail++; $display("FAIL basic_done_latency: got %0d want 3", c); end
    n_tests++;
    if (load_duration !== 1'b0) begin n_fail++; $display("FAIL basic_done_no_load: got %b want 0", load_duration); end
    @(negedge clk);
    n_tests++;
    if ({busy, song_done} !== 2'b00) begin n_fail++; $display("FAIL basic_idle: got %b want 00", {busy, song_done}); end
    n_tests++;
    if (n_loads - loads0 !== 2) begin n_fail++; $display("FAIL basic_load_count: got %0d want 2", n_loads - loads0); end
    // Held play must not retrigger the song.
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_no_retrigger: got %b want 0", busy); end
  endtask

  task automatic test_pause();
    int c;
    int loads0;
    logic [11:0] e;
    exp_q.push_back({6'd5, 6'd3});
    start_song(2'd2);
    wait_for(1'b0, 10, c);
    n_tests++;
    if (c !== 3) begin n_fail++; $display("FAIL pause_latency: got %0d want 3", c); end
    e = pop_exp();
    n_tests++;
    if ({note, duration} !== e) begin n_fail++; $display("FAIL pause_word: got %0h want %0h", {note, duration}, e); end
    @(negedge clk);
    loads0 = n_loads;
    play = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat = i[0];
      @(negedge clk);
      n_tests++;
      if ({beat_out, load_duration, dbg_state} !== {1'b0, 1'b0, S_WAIT}) begin
        n_fail++;
        $display("FAIL pause_hold c%0d: got bo=%b ld=%b st=%0d want 0/0/%0d", i, beat_out, load_duration, dbg_state, S_WAIT);
      end
    end
    play = 1'b1;
    for (int i = 0; i < 10; i++) begin
      beat = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if ({beat_out, dbg_state} !== {beat, S_WAIT}) begin
        n_fail++;
        $display("FAIL pause_resume c%0d: got bo=%b st=%0d want %b/%0d", i, beat_out, dbg_state, beat, S_WAIT);
      end
    end
    beat = 1'b0;
    advance_done = 1'b1;
    wait_for(1'b1, 10, c);
    n_tests++;
    if (c !== 3) begin n_fail++; $display("FAIL pause_done_latency: got %0d want 3", c); end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, 32'(n_loads - loads0)} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL pause_no_restart: got busy=%b loads=%0d want 0/0", busy, n_loads - loads0);
    end
  endtask

  task automatic test_full_song();
    int c;
    int loads0;
    int dones0;
    logic [11:0] e;
    loads0 = n_loads;
    dones0 = n_dones;
    for (int i = 0; i < 32; i++) exp_q.push_back({6'(i + 1), 6'((i % 3) + 1)});
    start_song(2'd0);
    for (int i = 0; i < 32; i++) begin
      wait_for(1'b0, 10, c);
      n_tests++;
      if (c !== 3) begin n_fail++; $display("FAIL full_latency n%0d: got %0d want 3", i, c); end
      e = pop_exp();
      n_tests++;
      if ({note, duration, rom_addr} !== {e, 7'(i)}) begin
        n_fail++;
        $display("FAIL full_load n%0d: got %0h addr=%0h want %0h/%0h", i, {note, duration}, rom_addr, e, i);
      end
      @(negedge clk);
      repeat ($urandom_range(0, 4)) begin
        beat = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      beat = 1'b0;
      advance_done = 1'b1;
    end
    wait_for(1'b1, 5, c);
    n_tests++;
    if (c !== 1) begin n_fail++; $display("FAIL full_done_latency: got %0d want 1", c); end
    n_tests++;
    if (rom_addr !== 7'h1F) begin n_fail++; $display("FAIL full_last_addr: got %0h want 1f", rom_addr); end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (n_loads - loads0 !== 32) begin n_fail++; $display("FAIL full_load_count: got %0d want 32", n_loads - loads0); end
    n_tests++;
    if ({busy, 32'(n_dones - dones0)} !== {1'b0, 32'd1}) begin
      n_fail++;
      $display("FAIL full_end: got busy=%b dones=%0d want 0/1", busy, n_dones - dones0);
    end
  endtask

  task automatic test_empty_song();
    int c;
    int loads0;
    loads0 = n_loads;
    start_song(2'd3);
    wait_for(1'b1, 10, c);
    n_tests++;
    if (c !== 3) begin n_fail++; $display("FAIL empty_done_latency: got %0d want 3", c); end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b want 0", busy); end
    n_tests++;
    if (n_loads - loads0 !== 0) begin n_fail++; $display("FAIL empty_no_load: got %0d want 0", n_loads - loads0); end
  endtask

  task automatic test_async_reset();
    int c;
    logic [11:0] e;
    exp_q.push_back({6'd10, 6'd2});
    start_song(2'd1);
    wait_for(1'b0, 10, c);
    e = pop_exp();
    n_tests++;
    if ({c, note, duration} !== {32'd3, e}) begin
      n_fail++;
      $display("FAIL areset_pre_load: got c=%0d word=%0h want 3/%0h", c, {note, duration}, e);
    end
    @(negedge clk);
    beat = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, load_duration, beat_out, song_done, new_note, dbg_state} !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_flags: got %b want 00000000", {busy, load_duration, beat_out, song_done, new_note, dbg_state});
    end
    n_tests++;
    if ({rom_addr, note, duration} !== 19'h0) begin
      n_fail++;
      $display("FAIL areset_data: got addr=%0h note=%0d dur=%0d want 0/0/0", rom_addr, note, duration);
    end
    @(negedge clk);
    reset = 1'b1;
    beat  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_no_restart c%0d: got busy=%b want 0", i, busy); end
    end
    exp_q.push_back({6'd10, 6'd2});
    exp_q.push_back({6'd20, 6'd1});
    start_song(2'd1);
    for (int n = 0; n < 2; n++) begin
      wait_for(1'b0, 10, c);
      e = pop_exp();
      n_tests++;
      if ({c, note, duration} !== {32'd3, e}) begin
        n_fail++;
        $display("FAIL areset_replay n%0d: got c=%0d word=%0h want 3/%0h", n, c, {note, duration}, e);
      end
      @(negedge clk);
      advance_done = 1'b1;
    end
    wait_for(1'b1, 10, c);
    n_tests++;
    if (c !== 3) begin n_fail++; $display("FAIL areset_replay_done: got %0d want 3", c); end
    @(negedge clk);
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    n_tests      = 0;
    n_fail       = 0;
    n_loads      = 0;
    n_dones      = 0;
    reset        = 1'b0;
    play         = 1'b0;
    song         = 2'd0;
    beat         = 1'b0;
    advance_done = 1'b0;
    test_reset();
`ifdef SEQ_LOOP_EN
    test_loop();
`else
    test_basic();
    test_pause();
    test_full_song();
    test_empty_song();
    test_async_reset();
`endif
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
